// File: rtl/spi_pixel_frame_ctrl.sv
// Command/frame controller: parses SPI byte frames into pixel writes, RAM clear sweeps
// and NeoPixel refresh requests.
module spi_pixel_frame_ctrl #(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              ssel_active,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [23:0]       pix_data,
  output logic              show_req,
  input  logic              show_ack,
  output logic              busy,
  output logic [7:0]        err_count
);

  // One spare index bit so "one past the last pixel" is representable without wrapping.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] NUM_IDX = IDX_W'(NUM_PIXELS);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [31:0]      NUM_P32 = 32'(NUM_PIXELS);

  localparam logic [2:0] ST_CMD     = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_G       = 3'd2;
  localparam logic [2:0] ST_R       = 3'd3;
  localparam logic [2:0] ST_B       = 3'd4;
  localparam logic [2:0] ST_DISCARD = 3'd5;
  localparam logic [2:0] ST_CLEAR   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        g_q, g_d;
  logic [7:0]        r_q, r_d;
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [23:0]       pix_data_q, pix_data_d;
  logic              show_req_q, show_req_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_q, err_d;
  logic              show_set;
  logic              err_inc;

  // Next-state, datapath and error detection for the frame parser and clear sweep.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    g_d        = g_q;
    r_d        = r_q;
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    busy_d     = 1'b0;
    show_set   = 1'b0;
    err_inc    = 1'b0;

    if (state_q == ST_CLEAR) begin
      // The sweep owns the RAM port; chip select and bytes are ignored (bytes count as errors).
      err_inc = rx_ready;
      if (idx_q < NUM_IDX) begin
        pix_we_d   = 1'b1;
        pix_addr_d = idx_q[ADDR_W-1:0];
        pix_data_d = 24'h00_0000;
        busy_d     = 1'b1;
        idx_d      = idx_q + IDX_ONE;
      end else if (ssel_active) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_CMD;
      end
    end else if (!ssel_active) begin
      state_d = ST_CMD;
    end else if (rx_ready) begin
      case (state_q)
        ST_CMD: begin
          case (rx_data)
            8'h01: state_d = ST_ADDR;
            8'h02: begin
              show_set = 1'b1;
              state_d  = ST_DISCARD;
            end
            8'h03: begin
              // First clear write issues together with entering the sweep.
              state_d    = ST_CLEAR;
              busy_d     = 1'b1;
              pix_we_d   = 1'b1;
              pix_addr_d = {ADDR_W{1'b0}};
              pix_data_d = 24'h00_0000;
              idx_d      = IDX_ONE;
            end
            default: begin
              err_inc = 1'b1;
              state_d = ST_DISCARD;
            end
          endcase
        end
        ST_ADDR: begin
          idx_d = IDX_W'(rx_data);
          if ({24'h00_0000, rx_data} >= NUM_P32) begin
            err_inc = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_G;
          end
        end
        ST_G: begin
          if (idx_q >= NUM_IDX) begin
            err_inc = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            g_d     = rx_data;
            state_d = ST_R;
          end
        end
        ST_R: begin
          r_d     = rx_data;
          state_d = ST_B;
        end
        ST_B: begin
          pix_we_d   = 1'b1;
          pix_addr_d = idx_q[ADDR_W-1:0];
          pix_data_d = {g_q, r_q, rx_data};
          idx_d      = idx_q + IDX_ONE;
          state_d    = ST_G;
        end
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_CMD;
      endcase
    end else begin
      state_d = state_q;
    end

    // A new SHOW wins over a coincident acknowledge.
    if (show_set) begin
      show_req_d = 1'b1;
    end else if (show_ack) begin
      show_req_d = 1'b0;
    end else begin
      show_req_d = show_req_q;
    end

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers; asynchronous reset aborts any frame or sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CMD;
      idx_q      <= {IDX_W{1'b0}};
      g_q        <= 8'h00;
      r_q        <= 8'h00;
      pix_we_q   <= 1'b0;
      pix_addr_q <= {ADDR_W{1'b0}};
      pix_data_q <= 24'h00_0000;
      show_req_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      g_q        <= g_d;
      r_q        <= r_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
      show_req_q <= show_req_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign pix_we    = pix_we_q;
  assign pix_addr  = pix_addr_q;
  assign pix_data  = pix_data_q;
  assign show_req  = show_req_q;
  assign busy      = busy_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_spi_pixel_frame_ctrl.sv
// Scoreboard bench for spi_pixel_frame_ctrl: expected pixel writes are queued as frames
// are driven and compared by a monitor whenever pix_we fires.
module tb_spi_pixel_frame_ctrl;

  localparam int NUM_PIXELS = 64;
  localparam int ADDR_W     = 6;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              ssel_active;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       pix_data;
  logic              show_req;
  logic              show_ack;
  logic              busy;
  logic [7:0]        err_count;

  int checks;
  int errors;
  int busy_cnt;
  logic mon_en;
  logic [7:0] exp_err;
  logic [29:0] exp_q[$];

  spi_pixel_frame_ctrl #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .ssel_active(ssel_active), .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_data(pix_data), .show_req(show_req), .show_ack(show_ack),
    .busy(busy), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every pix_we must match the head of the expectation queue.
  initial begin
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt = busy_cnt + 1;
      if (mon_en && pix_we === 1'b1) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_write: got addr=%0d data=%06h, required no write", pix_addr, pix_data);
        end else begin
          e = exp_q.pop_front();
          if ({pix_addr, pix_data} !== e) begin
            errors = errors + 1;
            $display("FAIL write: got addr=%0d data=%06h, required addr=%0d data=%06h",
                     pix_addr, pix_data, e[29:24], e[23:0]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    ssel_active = 1'b1;
  endtask

  task automatic frame_end();
    @(posedge clk); #1;
    ssel_active = 1'b0;
    tick(3);
  endtask

  task automatic expect_write(input logic [5:0] a, input logic [23:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_err(input string name);
    checks = checks + 1;
    if (err_count !== exp_err) begin
      errors = errors + 1;
      $display("FAIL %s: err_count got %0d, required %0d", name, err_count, exp_err);
    end
  endtask

  task automatic check_drained(input string name);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s: %0d expected writes never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks = checks + 1;
    if ({pix_we, pix_addr, pix_data, show_req, busy, err_count} !== 41'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%06h req=%b busy=%b err=%0d, required all 0",
               pix_we, pix_addr, pix_data, show_req, busy, err_count);
    end
  endtask

  task automatic test_write();
    expect_write(6'd5, 24'h112233);
    expect_write(6'd6, 24'h445566);
    frame_start();
    send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    checks = checks + 1;
    if (pix_we !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL write_latency: pix_we got %b one cycle after B byte, required 1", pix_we);
    end
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    frame_end();
    check_drained("write_two_pixels");
    check_err("write_no_error");
  endtask

  task automatic test_overflow();
    expect_write(6'd63, 24'hAABBCC);
    frame_start();
    send_byte(8'h01); send_byte(8'h3F);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hDD);
    exp_err = exp_err + 8'd1;
    frame_end();
    check_drained("last_pixel");
    check_err("index_overflow");
  endtask

  task automatic test_clear();
    for (int i = 0; i < NUM_PIXELS; i++) expect_write(6'(i), 24'h000000);
    busy_cnt = 0;
    frame_start();
    send_byte(8'h03);
    checks = checks + 1;
    if (busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL clear_busy_start: busy got %b after 0x03, required 1", busy);
    end
    for (int i = 0; i < 4; i++) send_byte(8'h5A + 8'(i));
    exp_err = exp_err + 8'd4;
    tick(70);
    frame_end();
    check_drained("clear_sweep");
    checks = checks + 1;
    if (busy_cnt != NUM_PIXELS) begin
      errors = errors + 1;
      $display("FAIL clear_busy_len: busy cycles got %0d, required %0d", busy_cnt, NUM_PIXELS);
    end
    check_err("clear_rx_errors");
  endtask

  task automatic test_show();
    frame_start(); send_byte(8'h02);
    checks = checks + 1;
    if (show_req !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL show_set: show_req got %b, required 1", show_req);
    end
    frame_end();
    frame_start(); send_byte(8'h02); frame_end();
    checks = checks + 1;
    if (show_req !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL show_repeat: show_req got %b, required 1", show_req);
    end
    check_err("show_repeat_err");
    @(posedge clk); #1; show_ack = 1'b1;
    @(posedge clk); #1; show_ack = 1'b0;
    checks = checks + 1;
    if (show_req !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL show_ack_clear: show_req got %b, required 0", show_req);
    end
    frame_start(); send_byte(8'h02); frame_end();
    frame_start();
    @(posedge clk); #1;
    rx_data = 8'h02; rx_ready = 1'b1; show_ack = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0; show_ack = 1'b0;
    checks = checks + 1;
    if (show_req !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL show_coincident: show_req got %b, required 1", show_req);
    end
    frame_end();
    @(posedge clk); #1; show_ack = 1'b1;
    @(posedge clk); #1; show_ack = 1'b0;
    checks = checks + 1;
    if (show_req !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL show_ack_clear2: show_req got %b, required 0", show_req);
    end
  endtask

  task automatic test_partial_drop();
    expect_write(6'd2, 24'hAABBCC);
    frame_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    frame_end();
    frame_start();
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    frame_end();
    check_drained("partial_drop");
    check_err("partial_no_error");
  endtask

  task automatic test_errors_and_abort();
    frame_start(); send_byte(8'h7F); frame_end();
    frame_start(); send_byte(8'h01); send_byte(8'h50); frame_end();
    exp_err = exp_err + 8'd2;
    check_err("bad_cmd_and_addr");
    mon_en = 1'b0;
    frame_start(); send_byte(8'h03);
    tick(10);
    #3 reset = 1'b0;
    #1;
    checks = checks + 1;
    if ({pix_we, pix_addr, pix_data, show_req, busy, err_count} !== 41'd0) begin
      errors = errors + 1;
      $display("FAIL abort_clear: we=%b addr=%0d data=%06h busy=%b err=%0d, required all 0",
               pix_we, pix_addr, pix_data, busy, err_count);
    end
    ssel_active = 1'b0;
    tick(2);
    reset = 1'b1;
    exp_q.delete();
    exp_err = 8'd0;
    tick(2);
    mon_en = 1'b1;
    expect_write(6'd7, 24'h010203);
    frame_start();
    send_byte(8'h01); send_byte(8'h07);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    frame_end();
    check_drained("after_abort_write");
    check_err("after_abort_err");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    busy_cnt    = 0;
    mon_en      = 1'b1;
    exp_err     = 8'd0;
    reset       = 1'b0;
    rx_data     = 8'h00;
    rx_ready    = 1'b0;
    ssel_active = 1'b0;
    show_ack    = 1'b0;
    #22 reset = 1'b1;
    test_reset();
    test_write();
    test_overflow();
    test_clear();
    test_show();
    test_partial_drop();
    test_errors_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
